// File: rtl/ibex_pkg.sv
// Shared Ibex types: the ALU operator set and the CHERI bounds-sequencer states.
// Only the subset of ibex_pkg used by this block is reproduced here.
package ibex_pkg;

    typedef enum logic [6:0] {
        ALU_ADD,
        ALU_SUB,
        ALU_XOR,
        ALU_OR,
        ALU_AND,
        ALU_LT,
        ALU_LTU,
        ALU_GE,
        ALU_GEU,
        ALU_EQ,
        ALU_NE
    } alu_op_e;

    typedef enum logic [2:0] {
        BSEQ_IDLE,
        BSEQ_ADD_TOP,
        BSEQ_CMP_TOP,
        BSEQ_CMP_BASE,
        BSEQ_DONE
    } cheri_bseq_state_e;

endpackage

// File: rtl/ibex_cheri_bounds_seq.sv
// Multi-cycle CSetBounds sequencer borrowing the shared integer ALU.
// Define IBEX_CHERI_BOUNDS_EARLY_ABORT_EN to skip the base check on a top failure.
module ibex_cheri_bounds_seq
    import ibex_pkg::*;
(
    input  logic          clk_i,
    input  logic          rst_ni,
    input  logic          start_i,
    input  logic          kill_i,
    input  logic [31:0]   addr_i,
    input  logic [31:0]   len_i,
    input  logic [31:0]   base_i,
    input  logic [32:0]   top_i,
    output logic          alu_sel_o,
    output alu_op_e       alu_operator_o,
    output logic [31:0]   alu_operand_a_o,
    output logic [31:0]   alu_operand_b_o,
    input  logic [33:0]   alu_adder_ext_i,
    input  logic          alu_cmp_i,
    input  logic          ready_id_i,
    output logic          busy_o,
    output logic          valid_o,
    output logic [31:0]   new_base_o,
    output logic [32:0]   new_top_o,
    output logic          length_exc_o
);

    cheri_bseq_state_e state_q, state_d;

    logic [31:0] addr_q;
    logic [31:0] len_q;
    logic [31:0] base_q;
    logic [32:0] top_q;
    logic [32:0] new_top_q;
    logic        top_fail_q;
    logic        base_fail_q;
    logic        capture;
    logic        top_ok;
    logic        unused_adder_lsb;

    assign unused_adder_lsb = alu_adder_ext_i[0];

    assign capture = (state_q == BSEQ_IDLE) & start_i & ~kill_i;

    // Carry bits decide the 33-bit compare; the ALU only resolves equal carries.
    always_comb begin
        if (top_q[32] != new_top_q[32]) begin
            top_ok = top_q[32];
        end else begin
            top_ok = alu_cmp_i;
        end
    end

    always_comb begin
        state_d         = state_q;
        alu_sel_o       = 1'b0;
        alu_operator_o  = ALU_ADD;
        alu_operand_a_o = '0;
        alu_operand_b_o = '0;
        valid_o         = 1'b0;
        length_exc_o    = 1'b0;
        unique case (state_q)
            BSEQ_IDLE: begin
                if (start_i) state_d = BSEQ_ADD_TOP;
            end
            BSEQ_ADD_TOP: begin
                alu_sel_o       = 1'b1;
                alu_operand_a_o = addr_q;
                alu_operand_b_o = len_q;
                state_d         = BSEQ_CMP_TOP;
            end
            BSEQ_CMP_TOP: begin
                alu_sel_o       = 1'b1;
                alu_operator_o  = ALU_GEU;
                alu_operand_a_o = top_q[31:0];
                alu_operand_b_o = new_top_q[31:0];
`ifdef IBEX_CHERI_BOUNDS_EARLY_ABORT_EN
                state_d = top_ok ? BSEQ_CMP_BASE : BSEQ_DONE;
`else
                state_d = BSEQ_CMP_BASE;
`endif
            end
            BSEQ_CMP_BASE: begin
                alu_sel_o       = 1'b1;
                alu_operator_o  = ALU_GEU;
                alu_operand_a_o = addr_q;
                alu_operand_b_o = base_q;
                state_d         = BSEQ_DONE;
            end
            BSEQ_DONE: begin
                valid_o      = 1'b1;
                length_exc_o = top_fail_q | base_fail_q;
                if (ready_id_i) state_d = BSEQ_IDLE;
            end
            default: state_d = BSEQ_IDLE;
        endcase
        if (kill_i) state_d = BSEQ_IDLE;
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q     <= BSEQ_IDLE;
            addr_q      <= '0;
            len_q       <= '0;
            base_q      <= '0;
            top_q       <= '0;
            new_top_q   <= '0;
            top_fail_q  <= 1'b0;
            base_fail_q <= 1'b0;
        end else begin
            state_q <= state_d;
            if (capture) begin
                addr_q <= addr_i;
                len_q  <= len_i;
                base_q <= base_i;
                top_q  <= top_i;
            end
            if (state_q == BSEQ_ADD_TOP) begin
                new_top_q <= alu_adder_ext_i[33:1];
            end
            if (kill_i || capture) begin
                top_fail_q  <= 1'b0;
                base_fail_q <= 1'b0;
            end else begin
                if (state_q == BSEQ_CMP_TOP) top_fail_q <= ~top_ok;
                if (state_q == BSEQ_CMP_BASE) base_fail_q <= ~alu_cmp_i;
            end
        end
    end

    assign busy_o     = (state_q != BSEQ_IDLE);
    assign new_base_o = addr_q;
    assign new_top_o  = new_top_q;

endmodule

// File: tb/tb_ibex_cheri_bounds_seq.sv
// Directed bench for ibex_cheri_bounds_seq with a behavioural model of the shared ALU.
// Expected latencies follow IBEX_CHERI_BOUNDS_EARLY_ABORT_EN when it is defined.
module tb_ibex_cheri_bounds_seq;
    import ibex_pkg::*;

`ifdef IBEX_CHERI_BOUNDS_EARLY_ABORT_EN
    localparam int FAIL_LAT = 3;
    localparam int FAIL_SEL = 2;
`else
    localparam int FAIL_LAT = 4;
    localparam int FAIL_SEL = 3;
`endif

    logic        clk_i = 1'b0;
    logic        rst_ni = 1'b0;
    logic        start_i = 1'b0;
    logic        kill_i = 1'b0;
    logic [31:0] addr_i = '0;
    logic [31:0] len_i = '0;
    logic [31:0] base_i = '0;
    logic [32:0] top_i = '0;
    logic        alu_sel_o;
    alu_op_e     alu_operator_o;
    logic [31:0] alu_operand_a_o;
    logic [31:0] alu_operand_b_o;
    logic [33:0] alu_adder_ext_i;
    logic        alu_cmp_i;
    logic        ready_id_i = 1'b0;
    logic        busy_o;
    logic        valid_o;
    logic [31:0] new_base_o;
    logic [32:0] new_top_o;
    logic        length_exc_o;

    int checks = 0;
    int errors = 0;

    always #5 clk_i = ~clk_i;

    // Shared ALU: adder with Ibex-style extended operands, unsigned compare.
    always_comb begin
        alu_adder_ext_i = {1'b0, alu_operand_a_o, 1'b1}
                        + {1'b0, alu_operand_b_o, 1'b0};
        alu_cmp_i = (alu_operator_o == ALU_GEU) ?
                    (alu_operand_a_o >= alu_operand_b_o) : 1'b0;
    end

    ibex_cheri_bounds_seq dut (
        .clk_i           (clk_i),
        .rst_ni          (rst_ni),
        .start_i         (start_i),
        .kill_i          (kill_i),
        .addr_i          (addr_i),
        .len_i           (len_i),
        .base_i          (base_i),
        .top_i           (top_i),
        .alu_sel_o       (alu_sel_o),
        .alu_operator_o  (alu_operator_o),
        .alu_operand_a_o (alu_operand_a_o),
        .alu_operand_b_o (alu_operand_b_o),
        .alu_adder_ext_i (alu_adder_ext_i),
        .alu_cmp_i       (alu_cmp_i),
        .ready_id_i      (ready_id_i),
        .busy_o          (busy_o),
        .valid_o         (valid_o),
        .new_base_o      (new_base_o),
        .new_top_o       (new_top_o),
        .length_exc_o    (length_exc_o)
    );

    typedef struct {
        logic [31:0] addr;
        logic [31:0] len;
        logic [31:0] base;
        logic [32:0] top;
        logic [32:0] exp_top;
        logic        exp_exc;
        int          exp_lat;
        int          exp_sel;
        int          hold;
    } vec_t;

    vec_t vecs[8];

    task automatic check(input string name, input logic [63:0] act,
                         input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic run_op(input vec_t v, input string tag);
        int lat;
        int sel;
        @(negedge clk_i);
        addr_i  = v.addr;
        len_i   = v.len;
        base_i  = v.base;
        top_i   = v.top;
        start_i = 1'b1;
        @(posedge clk_i);
        #1;
        start_i = 1'b0;
        // Scramble inputs to show the captured copy is used.
        addr_i = ~v.addr;
        len_i  = ~v.len;
        base_i = ~v.base;
        top_i  = ~v.top;
        lat = 1;
        sel = 0;
        while (!valid_o && lat < 20) begin
            if (alu_sel_o) sel++;
            @(posedge clk_i);
            #1;
            lat++;
        end
        check({tag, " valid"}, 64'(valid_o), 64'd1);
        check({tag, " latency"}, 64'(lat), 64'(v.exp_lat));
        check({tag, " alu_sel cycles"}, 64'(sel), 64'(v.exp_sel));
        check({tag, " new_top"}, 64'(new_top_o), 64'(v.exp_top));
        check({tag, " new_base"}, 64'(new_base_o), 64'(v.addr));
        check({tag, " length_exc"}, 64'(length_exc_o), 64'(v.exp_exc));
        for (int i = 0; i < v.hold; i++) begin
            @(posedge clk_i);
            #1;
            check({tag, " hold valid"}, 64'(valid_o), 64'd1);
            check({tag, " hold top"}, 64'(new_top_o), 64'(v.exp_top));
            check({tag, " hold exc"}, 64'(length_exc_o), 64'(v.exp_exc));
        end
        ready_id_i = 1'b1;
        @(posedge clk_i);
        #1;
        ready_id_i = 1'b0;
        check({tag, " idle after ready"}, 64'(busy_o), 64'd0);
        check({tag, " valid drops"}, 64'(valid_o), 64'd0);
    endtask

    initial begin
        int vcount;
        int idle_cnt;

        vecs[0] = '{32'h1000, 32'h100, 32'h0800, 33'h0_0000_2000,
                    33'h0_0000_1100, 1'b0, 4, 3, 0};
        vecs[1] = '{32'hFFFF_FF00, 32'h200, 32'h0, 33'h1_0000_0000,
                    33'h1_0000_0100, 1'b1, FAIL_LAT, FAIL_SEL, 3};
        vecs[2] = '{32'h0400, 32'h100, 32'h0800, 33'h0_0000_2000,
                    33'h0_0000_0500, 1'b1, 4, 3, 0};
        vecs[3] = '{32'h0800, 32'h1800, 32'h0800, 33'h0_0000_2000,
                    33'h0_0000_2000, 1'b0, 4, 3, 0};
        vecs[4] = '{32'h0800, 32'h1801, 32'h0800, 33'h0_0000_2000,
                    33'h0_0000_2001, 1'b1, FAIL_LAT, FAIL_SEL, 1};
        vecs[5] = '{32'hFFFF_F000, 32'h1000, 32'h0, 33'h1_0000_0000,
                    33'h1_0000_0000, 1'b0, 4, 3, 0};
        vecs[6] = '{32'h0010, 32'h10, 32'h0, 33'h1_0000_0000,
                    33'h0_0000_0020, 1'b0, 4, 3, 0};
        vecs[7] = '{32'h1000, 32'h0, 32'h1000, 33'h0_0000_1000,
                    33'h0_0000_1000, 1'b0, 4, 3, 0};

        #12;
        check("reset busy", 64'(busy_o), 64'd0);
        check("reset valid", 64'(valid_o), 64'd0);
        check("reset alu_sel", 64'(alu_sel_o), 64'd0);
        check("reset exc", 64'(length_exc_o), 64'd0);
        check("reset new_base", 64'(new_base_o), 64'd0);
        check("reset new_top", 64'(new_top_o), 64'd0);
        check("reset operator", 64'(alu_operator_o), 64'(ALU_ADD));
        check("reset operand a", 64'(alu_operand_a_o), 64'd0);
        rst_ni = 1'b1;

        for (int i = 0; i < 8; i++) begin
            run_op(vecs[i], $sformatf("vec%0d", i));
        end

        // Kill in CMP_TOP.
        @(negedge clk_i);
        addr_i = 32'h1000; len_i = 32'h100;
        base_i = 32'h800; top_i = 33'h2000;
        start_i = 1'b1;
        @(posedge clk_i);
        #1;
        start_i = 1'b0;
        @(posedge clk_i);
        #1;
        check("kill pre state sel", 64'(alu_operator_o), 64'(ALU_GEU));
        kill_i = 1'b1;
        @(posedge clk_i);
        #1;
        kill_i = 1'b0;
        check("kill idle", 64'(busy_o), 64'd0);
        vcount = 0;
        for (int i = 0; i < 6; i++) begin
            if (valid_o) vcount++;
            @(posedge clk_i);
            #1;
        end
        check("kill no valid", 64'(vcount), 64'd0);
        run_op(vecs[0], "after kill");

        // start held across DONE with ready high.
        @(negedge clk_i);
        addr_i = 32'h1000; len_i = 32'h100;
        base_i = 32'h800; top_i = 33'h2000;
        start_i = 1'b1;
        ready_id_i = 1'b1;
        vcount = 0;
        for (int i = 0; i < 20 && vcount == 0; i++) begin
            @(posedge clk_i);
            #1;
            if (valid_o) vcount++;
        end
        check("held start one done", 64'(vcount), 64'd1);
        @(posedge clk_i);
        #1;
        start_i = 1'b0;
        ready_id_i = 1'b0;
        check("held start idle", 64'(busy_o), 64'd0);
        idle_cnt = 0;
        for (int i = 0; i < 6; i++) begin
            @(posedge clk_i);
            #1;
            if (busy_o || valid_o) idle_cnt++;
        end
        check("held start no requeue", 64'(idle_cnt), 64'd0);

        // Reset in the middle of an operation.
        @(negedge clk_i);
        addr_i = 32'h1000; len_i = 32'h100;
        base_i = 32'h800; top_i = 33'h2000;
        start_i = 1'b1;
        @(posedge clk_i);
        #1;
        start_i = 1'b0;
        @(posedge clk_i);
        #3;
        rst_ni = 1'b0;
        #1;
        check("midreset busy", 64'(busy_o), 64'd0);
        check("midreset new_top", 64'(new_top_o), 64'd0);
        check("midreset new_base", 64'(new_base_o), 64'd0);
        @(negedge clk_i);
        rst_ni = 1'b1;
        vcount = 0;
        for (int i = 0; i < 6; i++) begin
            @(posedge clk_i);
            #1;
            if (valid_o) vcount++;
        end
        check("midreset no valid", 64'(vcount), 64'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: got running expected finished");
        $fatal(1);
    end

endmodule

// File: doc/ibex_cheri_bounds_seq.md
IBEX_CHERI_BOUNDS_SEQ -- requirements
Module: ibex_cheri_bounds_seq

Interface
REQ-001 The block SHALL have no parameters; all widths SHALL be fixed as listed.
REQ-002 The port clk_i SHALL be an input, 1 bit wide, and SHALL be the single clock; all state SHALL update on its rising edge.
REQ-003 The port rst_ni SHALL be an input, 1 bit wide, providing an asynchronous, active-low reset.
REQ-004 The port start_i SHALL be an input, 1 bit wide, requesting one bounds-setting operation.
REQ-005 The port kill_i SHALL be an input, 1 bit wide, flushing the current operation.
REQ-006 The port addr_i SHALL be an input, 32 bits wide, carrying the capability cursor (the new base).
REQ-007 The port len_i SHALL be an input, 32 bits wide, carrying the requested length.
REQ-008 The port base_i SHALL be an input, 32 bits wide, carrying the old capability base.
REQ-009 The port top_i SHALL be an input, 33 bits wide, carrying the old capability top.
REQ-010 The port alu_sel_o SHALL be an output, 1 bit wide, granting the shared integer ALU to this block.
REQ-011 The port alu_operator_o SHALL be an output of type ibex_pkg::alu_op_e, carrying the ALU operator.
REQ-012 The port alu_operand_a_o SHALL be an output, 32 bits wide, carrying ALU operand A.
REQ-013 The port alu_operand_b_o SHALL be an output, 32 bits wide, carrying ALU operand B.
REQ-014 The port alu_adder_ext_i SHALL be an input, 34 bits wide, carrying the extended adder result; the 33-bit sum SHALL be taken from bits [33:1].
REQ-015 The port alu_cmp_i SHALL be an input, 1 bit wide, carrying the ALU comparison result.
REQ-016 The port ready_id_i SHALL be an input, 1 bit wide, indicating that the ID stage accepts the result.
REQ-017 The port busy_o SHALL be an output, 1 bit wide, high whenever the state is not IDLE.
REQ-018 The port valid_o SHALL be an output, 1 bit wide, indicating that the result is valid.
REQ-019 The port new_base_o SHALL be an output, 32 bits wide, carrying the resulting base.
REQ-020 The port new_top_o SHALL be an output, 33 bits wide, carrying the resulting top.
REQ-021 The port length_exc_o SHALL be an output, 1 bit wide, flagging a bounds (length) violation; it SHALL be qualified by valid_o.

Function
REQ-022 The FSM SHALL have the states IDLE, ADD_TOP, CMP_TOP, CMP_BASE and DONE, held in a 3-bit register.
REQ-023 In IDLE, when start_i=1 and kill_i=0, the block SHALL capture addr_i, len_i, base_i and top_i into internal registers and move to ADD_TOP.
REQ-024 In ADD_TOP, the block SHALL drive alu_sel_o=1, operator ALU_ADD, a=addr, b=len; it SHALL register new_top=alu_adder_ext_i[33:1] (33 bits, carry retained) and move to CMP_TOP.
REQ-025 In CMP_TOP, the block SHALL drive ALU_GEU with a=top[31:0] and b=new_top[31:0].
REQ-026 In CMP_TOP, the top check SHALL pass if top[32]>new_top[32], SHALL fail if top[32]<new_top[32], and SHALL otherwise equal alu_cmp_i.
REQ-027 The block SHALL register the inverse of the CMP_TOP result into a top_fail flag.
REQ-028 In CMP_BASE, the block SHALL drive ALU_GEU with a=addr and b=base; base_fail SHALL be the registered value of ~alu_cmp_i; the state SHALL then move to DONE.
REQ-029 In DONE, the block SHALL drive valid_o=1 and length_exc_o=top_fail|base_fail, with new_base_o=addr and new_top_o=new_top held stable.
REQ-030 In DONE, the state SHALL stay in DONE until ready_id_i=1, then SHALL return to IDLE.
REQ-031 Latency SHALL be 4 cycles from the start_i sample edge to the first valid_o cycle (3 cycles under the REQ-041 early-abort path).
REQ-032 A start_i asserted while busy_o=1, including the DONE cycle in which ready_id_i=1, SHALL be ignored; there SHALL be no queueing.
REQ-033 Outside ADD_TOP, CMP_TOP and CMP_BASE, the block SHALL drive alu_sel_o=0, operator ALU_ADD and both operands to 0.
REQ-034 Outside DONE, the block SHALL drive valid_o=0 and length_exc_o=0.
REQ-035 kill_i=1 in any state SHALL force IDLE on the next edge and clear top_fail and base_fail; kill_i SHALL take priority over start_i and ready_id_i.
REQ-036 Input changes after capture SHALL NOT affect the operation in progress.

Reset
REQ-037 While rst_ni=0, the state SHALL be IDLE and all internal registers (captured inputs, new_top, top_fail, base_fail) SHALL be 0.
REQ-038 From reset, outputs SHALL be busy_o=0, valid_o=0, alu_sel_o=0, length_exc_o=0, new_base_o=0 and new_top_o=0.
REQ-039 Reset asserted mid-operation SHALL abandon the operation with no valid_o pulse.

Configuration
REQ-040 The macro IBEX_CHERI_BOUNDS_EARLY_ABORT_EN SHALL control the early-abort feature.
REQ-041 With the macro defined, CMP_TOP with a failing top check SHALL go directly to DONE, skipping CMP_BASE, with base_fail=0 and length_exc_o=1.
REQ-042 Without the macro, CMP_TOP SHALL always go to CMP_BASE, with a fixed 4-cycle latency independent of data.

Structure
REQ-043 The state enum type cheri_bseq_state_e SHALL be added to ibex_pkg.
REQ-044 The block SHALL reuse ibex_pkg::alu_op_e for the ALU operator.
REQ-045 The block SHALL contain no sub-modules; the integer ALU SHALL remain external, and the ex block SHALL mux this block's operator and operands into the ALU when alu_sel_o=1.

Verification
REQ-046 The bench SHALL check: addr=0x1000, len=0x100, base=0x0800, top=0x0_2000 -> valid_o 4 cycles after start, new_top_o=0x0_1100, new_base_o=0x1000, length_exc_o=0.
REQ-047 The bench SHALL check: addr=0xFFFF_FF00, len=0x200, top=0x1_0000_0000 -> new_top_o=0x1_0000_0100, length_exc_o=1, with the result held across 3 cycles of ready_id_i=0.
REQ-048 The bench SHALL check: addr=0x0400, base=0x0800, in-range top -> length_exc_o=1 via base_fail.
REQ-049 The bench SHALL check: kill_i=1 in CMP_TOP -> IDLE on the next cycle, no valid_o, and a following start completes normally.
REQ-050 The bench SHALL check: start_i held high across DONE with ready_id_i=1 -> exactly one operation completes, then IDLE for at least 1 cycle.
REQ-051 The bench SHALL check, with IBEX_CHERI_BOUNDS_EARLY_ABORT_EN defined and a top violation: valid_o 3 cycles after start with alu_sel_o high for exactly 2 cycles; without the macro: 4 cycles and 3 cycles respectively.
